// File: rtl/wave_ram_arbiter.sv
// wave_ram_arbiter: shares the single-port 512x8 wave sample RAM between the
// display reader (priority) and the capture writer (queued in a small FIFO).
// A starvation guard forces the queue head out after STARVE_LIMIT blocked cycles.
// Optional feature macro: WAVE_ARB_STATS_EN builds the saturating overrun counter;
// without it overrun_count is tied to zero and drops still happen.
module wave_ram_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  input  logic       read_index,
  output logic       rd_grant,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic [8:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       fifo_full,
  output logic [7:0] overrun_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_entry_t;

  // Arbitration situation, decoded each cycle from queue occupancy and starvation.
  typedef enum logic [1:0] {
    ARB_EMPTY,
    ARB_QUEUED,
    ARB_FORCED
  } arb_state_e;

  wr_entry_t        fifo_mem [FIFO_DEPTH];
  wr_entry_t        head;
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       starve_cnt;
  arb_state_e       state;
  logic             pop;
  logic             push_ok;

  assign head      = fifo_mem[head_ptr];
  assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok   = wr_en && (!fifo_full || pop);
  assign rd_data   = ram_rdata;

  // Decode the arbitration situation from the registered queue state.
  always_comb begin
    state = ARB_EMPTY;
    if (count != '0) begin
      state = (starve_cnt >= 8'(STARVE_LIMIT)) ? ARB_FORCED : ARB_QUEUED;
    end
  end

  // Choose read, write or idle for this cycle and drive the RAM port.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    rd_grant  = 1'b0;
    pop       = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {read_index, rd_addr};
    ram_wdata = '0;
    if (reset) begin
      case (state)
        ARB_EMPTY:  rd_grant = rd_req;
        ARB_QUEUED: begin
          if (rd_req) rd_grant = 1'b1;
          else        pop      = 1'b1;
        end
        ARB_FORCED: pop = 1'b1;
        default:    pop = 1'b0;
      endcase
    end
    if (pop) begin
      // The queued bank bit is used as captured, independent of read_index.
      ram_we    = 1'b1;
      ram_addr  = head.addr;
      ram_wdata = head.data;
    end
    if (!reset) ram_addr = '0;
  end

  // Queue storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    if (push_ok) fifo_mem[tail_ptr] <= '{addr: wr_addr, data: wr_data};
  end

  // Queue pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
      if (push_ok) tail_ptr <= tail_ptr + 1'b1;
      if (pop)     head_ptr <= head_ptr + 1'b1;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // Starvation counter: counts cycles a queued write waits behind reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (pop || state == ARB_EMPTY) begin
      starve_cnt <= '0;
    end else if (starve_cnt < 8'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Read data from the RAM is valid one cycle after the grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= rd_grant;
  end

`ifdef WAVE_ARB_STATS_EN
  logic overrun;
  assign overrun = wr_en && fifo_full && !pop;

  // Saturating count of pushes dropped because the queue was full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              overrun_count <= '0;
    else if (overrun && overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
  end
`else
  assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// tb_wave_ram_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbiter and a behavioural sample RAM.
module tb_wave_ram_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WAVE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       read_index;
  logic       rd_grant;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       fifo_full;
  logic [7:0] overrun_count;

  int n_vec = 0;
  int n_err = 0;

  wave_ram_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .read_index(read_index), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fifo_full(fifo_full),
    .overrun_count(overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of the sample RAM; chosen so 9'h13C holds 8'hA5.
  function automatic logic [7:0] init_val(input logic [8:0] a);
    return a[7:0] ^ (a[8] ? 8'h99 : 8'h00);
  endfunction

  // Behavioural single-port RAM with registered read data.
  logic [7:0] ram_mem [512];
  bit         ram_written [512];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr]     <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end else begin
      ram_rdata <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
    end
  end

  // Reference model state.
  typedef struct packed {
    logic [8:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t        mq[$];
  int         m_starve;
  bit         m_prev_grant;
  logic [7:0] m_rdata;
  int         m_ovf;
  logic [7:0] exp_mem [512];

  // Expected outputs for the cycle just driven.
  logic       e_grant, e_we, e_valid, e_full;
  logic [8:0] e_addr;
  logic [7:0] e_wdata, e_rdata, e_ovf;

  task automatic m_reset();
    mq.delete();
    m_starve     = 0;
    m_prev_grant = 1'b0;
    m_ovf        = 0;
  endtask

  // Drive one cycle of inputs, compute this cycle's expected outputs, advance the model.
  task automatic step(input bit rq, input logic [7:0] ra, input bit ri,
                      input bit we, input logic [8:0] wa, input logic [7:0] wd);
    bit wr_now;
    bit was_empty;
    @(negedge clk);
    rd_req = rq; rd_addr = ra; read_index = ri;
    wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    e_valid   = m_prev_grant;
    e_rdata   = m_rdata;
    e_full    = (mq.size() == DEPTH);
    e_ovf     = 8'(m_ovf);
    was_empty = (mq.size() == 0);
    wr_now    = !was_empty && (m_starve >= LIMIT || !rq);
    e_we      = wr_now;
    e_grant   = rq && !wr_now;
    e_addr    = wr_now ? mq[0].addr : {ri, ra};
    e_wdata   = wr_now ? mq[0].data : 8'h00;
    if (wr_now) begin
      exp_mem[mq[0].addr] = mq[0].data;
      void'(mq.pop_front());
    end
    if (e_grant) m_rdata = exp_mem[{ri, ra}];
    m_prev_grant = e_grant;
    if (we) begin
      if (mq.size() < DEPTH) mq.push_back('{addr: wa, data: wd});
      else if (STATS && m_ovf < 255) m_ovf++;
    end
    m_starve = (wr_now || was_empty) ? 0 : m_starve + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; read_index = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1 reset = 1'b0;
    rd_req = 1'b1; wr_en = 1'b1; wr_addr = 9'h011; wr_data = 8'h22; rd_addr = 8'h33;
    #1;
    n_vec++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0", rd_grant); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", ram_we); end
    n_vec++; if (ram_addr !== 9'h000) begin n_err++; $display("FAIL reset_addr: got %h want 000", ram_addr); end
    @(posedge clk); #1;
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_hold_valid: got %b want 0", rd_valid); end
    n_vec++; if (fifo_full !== 1'b0) begin n_err++; $display("FAIL reset_hold_full: got %b want 0", fifo_full); end
    n_vec++; if (overrun_count !== 8'h00) begin n_err++; $display("FAIL reset_hold_ovf: got %h want 00", overrun_count); end
    rd_req = 1'b0; wr_en = 1'b0;
    @(negedge clk); reset = 1'b1;
    m_reset();
    // Mid-traffic reset: queued writes and a pending rd_valid must vanish.
    step(1'b1, 8'h10, 1'b0, 1'b1, 9'h0A0, 8'h11);
    step(1'b1, 8'h11, 1'b0, 1'b1, 9'h0A1, 8'h22);
    step(1'b1, 8'h12, 1'b1, 1'b0, 9'h000, 8'h00);
    #1 reset = 1'b0;
    #1;
    n_vec++; if (rd_grant !== 1'b0) begin n_err++; $display("FAIL midreset_grant: got %b want 0", rd_grant); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid: got %b want 0", rd_valid); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL midreset_we: got %b want 0", ram_we); end
    rd_req = 1'b0; wr_en = 1'b0;
    m_reset();
    @(negedge clk); reset = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL postreset_empty: ram_we=%b want 0", ram_we); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL postreset_valid: got %b want 0", rd_valid); end
  endtask

  task automatic test_read_only();
    step(1'b1, 8'h3C, 1'b1, 1'b0, 9'h000, 8'h00);
    n_vec++; if (rd_grant !== 1'b1) begin n_err++; $display("FAIL read_grant: got %b want 1", rd_grant); end
    n_vec++; if (ram_addr !== 9'h13C) begin n_err++; $display("FAIL read_addr: got %h want 13c", ram_addr); end
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL read_we: got %b want 0", ram_we); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL read_valid: got %b want 1", rd_valid); end
    n_vec++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL read_data: got %h want a5", rd_data); end
  endtask

  task automatic test_write_idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 9'h005, 8'h7F);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL write_latency: ram_we=%b want 0", ram_we); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 8'h00);
    n_vec++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL write_we: got %b want 1", ram_we); end
    n_vec++; if (ram_addr !== 9'h005) begin n_err++; $display("FAIL write_addr: got %h want 005", ram_addr); end
    n_vec++; if (ram_wdata !== 8'h7F) begin n_err++; $display("FAIL write_data: got %h want 7f", ram_wdata); end
    step(1'b1, 8'h05, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (ram_addr !== 9'h005) begin n_err++; $display("FAIL readback_addr: got %h want 005", ram_addr); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (rd_data !== 8'h7F) begin n_err++; $display("FAIL readback_data: got %h want 7f", rd_data); end
  endtask

  task automatic test_starvation();
    step(1'b1, 8'h20, 1'b0, 1'b1, 9'h1AA, 8'h33);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 8'(k), k[0], 1'b0, 9'h000, 8'h00);
      if (k == 9) begin
        n_vec++; if (rd_grant !== 1'b0 || ram_we !== 1'b1) begin n_err++; $display("FAIL starve_force: grant=%b we=%b want 0/1 at N+%0d", rd_grant, ram_we, k); end
        n_vec++; if (ram_addr !== 9'h1AA || ram_wdata !== 8'h33) begin n_err++; $display("FAIL starve_wr: addr=%h data=%h want 1aa/33", ram_addr, ram_wdata); end
      end else begin
        n_vec++; if (rd_grant !== 1'b1 || ram_we !== 1'b0) begin n_err++; $display("FAIL starve_read: grant=%b we=%b want 1/0 at N+%0d", rd_grant, ram_we, k); end
        n_vec++; if (ram_addr !== {k[0], 8'(k)}) begin n_err++; $display("FAIL starve_raddr: got %h want %h", ram_addr, {k[0], 8'(k)}); end
      end
    end
  endtask

  task automatic test_overrun();
    int ovf0;
    ovf0 = m_ovf;
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 9'h040 + 9'(i), 8'hC0 + 8'(i));
    step(1'b1, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL overrun_full: got %b want 1", fifo_full); end
    n_vec++; if (overrun_count !== (STATS ? 8'(ovf0 + 2) : 8'h00)) begin n_err++; $display("FAIL overrun_count: got %0d want %0d", overrun_count, STATS ? ovf0 + 2 : 0); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 8'h00);
      n_vec++; if (ram_we !== 1'b1 || ram_addr !== 9'h040 + 9'(i) || ram_wdata !== 8'hC0 + 8'(i)) begin
        n_err++; $display("FAIL overrun_drain%0d: we=%b addr=%h data=%h want 1/%h/%h", i, ram_we, ram_addr, ram_wdata, 9'h040 + 9'(i), 8'hC0 + 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (fifo_full !== 1'b0 || ram_we !== 1'b0) begin n_err++; $display("FAIL overrun_empty: full=%b we=%b want 0/0", fifo_full, ram_we); end
  endtask

  task automatic test_full_push_pop();
    logic [8:0] order [4];
    int ovf0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h00, 1'b0, 1'b1, 9'h180 + 9'(i), 8'h50 + 8'(i));
    step(1'b1, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fpp_full_before: got %b want 1", fifo_full); end
    ovf0 = m_ovf;
    step(1'b0, 8'h00, 1'b0, 1'b1, 9'h1F0, 8'hEE);
    n_vec++; if (ram_we !== 1'b1 || ram_addr !== 9'h180) begin n_err++; $display("FAIL fpp_pop: we=%b addr=%h want 1/180", ram_we, ram_addr); end
    step(1'b1, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL fpp_full_after: got %b want 1", fifo_full); end
    n_vec++; if (overrun_count !== 8'(ovf0)) begin n_err++; $display("FAIL fpp_ovf: got %0d want %0d", overrun_count, ovf0); end
    order[0] = 9'h181; order[1] = 9'h182; order[2] = 9'h183; order[3] = 9'h1F0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
      n_vec++; if (ram_we !== 1'b1 || ram_addr !== order[i]) begin n_err++; $display("FAIL fpp_drain%0d: we=%b addr=%h want 1/%h", i, ram_we, ram_addr, order[i]); end
    end
  endtask

  task automatic test_random();
    int p_rd, p_wr;
    for (int c = 0; c < 3000; c++) begin
      p_rd = (c / 500) % 3 == 0 ? 90 : ((c / 500) % 3 == 1 ? 50 : 15);
      p_wr = (c / 250) % 2 == 0 ? 60 : 25;
      step($urandom_range(0, 99) < p_rd, 8'($urandom), 1'($urandom),
           $urandom_range(0, 99) < p_wr, 9'($urandom), 8'($urandom));
      n_vec++; if (rd_grant !== e_grant) begin n_err++; $display("FAIL rnd_grant c%0d: got %b want %b", c, rd_grant, e_grant); end
      n_vec++; if (ram_we !== e_we) begin n_err++; $display("FAIL rnd_we c%0d: got %b want %b", c, ram_we, e_we); end
      n_vec++; if (ram_addr !== e_addr) begin n_err++; $display("FAIL rnd_addr c%0d: got %h want %h", c, ram_addr, e_addr); end
      if (e_we) begin
        n_vec++; if (ram_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, ram_wdata, e_wdata); end
      end
      n_vec++; if (rd_valid !== e_valid) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, rd_valid, e_valid); end
      if (e_valid) begin
        n_vec++; if (rd_data !== e_rdata) begin n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rd_data, e_rdata); end
      end
      n_vec++; if (fifo_full !== e_full) begin n_err++; $display("FAIL rnd_full c%0d: got %b want %b", c, fifo_full, e_full); end
      n_vec++; if (overrun_count !== e_ovf) begin n_err++; $display("FAIL rnd_ovf c%0d: got %0d want %0d", c, overrun_count, e_ovf); end
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 400; c++) step(1'b1, 8'($urandom), 1'($urandom), 1'b1, 9'($urandom), 8'($urandom));
    step(1'b1, 8'h00, 1'b0, 1'b0, 9'h000, 8'h00);
    n_vec++; if (overrun_count !== (STATS ? 8'hFF : 8'h00)) begin n_err++; $display("FAIL sat_ovf: got %0d want %0d", overrun_count, STATS ? 255 : 0); end
    n_vec++; if (overrun_count !== e_ovf) begin n_err++; $display("FAIL sat_model: got %0d want %0d", overrun_count, e_ovf); end
    n_vec++; if (fifo_full !== 1'b1) begin n_err++; $display("FAIL sat_full: got %b want 1", fifo_full); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) exp_mem[i] = init_val(9'(i));
    m_rdata = 8'h00;
    m_reset();
    test_reset();
    test_read_only();
    test_write_idle();
    test_starvation();
    test_overrun();
    test_full_push_pop();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
